// File: rtl/tb_cmd_executor.sv
// Script command executor: decodes one ASCII command line per args_valid strobe,
// drives/monitors the DUT-facing signal banks and returns a one-cycle ack.
module tb_cmd_executor #(
   parameter int N_SET     = 4,
   parameter int N_WAIT    = 4,
   parameter int N_CHK     = 4,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 10000,
   parameter int ARG_CHARS = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [8*ARG_CHARS-1:0] args [5],
   input  logic                   args_valid,
   output logic                   ack,
   output logic [DATA_W-1:0]      set_out [N_SET],
   input  logic [N_WAIT-1:0]      wait_in,
   input  logic [DATA_W-1:0]      chk_in [N_CHK],
   output logic                   busy,
   output logic [15:0]            err_cnt,
   output logic                   timeout_flag,
   output logic                   test_done
);
   localparam int NUM_W = (DATA_W > 32) ? DATA_W : 32;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int SI_W  = (N_SET > 1) ? $clog2(N_SET) : 1;
   localparam int WI_W  = (N_WAIT > 1) ? $clog2(N_WAIT) : 1;
   localparam int CI_W  = (N_CHK > 1) ? $clog2(N_CHK) : 1;

   // Arguments are right-justified ASCII, zero-padded on the left.
   localparam logic [8*ARG_CHARS-1:0] CMD_SET  = "SET";
   localparam logic [8*ARG_CHARS-1:0] CMD_WCLK = "WAIT_CLK";
   localparam logic [8*ARG_CHARS-1:0] CMD_WTR  = "WTR";
   localparam logic [8*ARG_CHARS-1:0] CMD_WTF  = "WTF";
   localparam logic [8*ARG_CHARS-1:0] CMD_CHK  = "CHK";
   localparam logic [8*ARG_CHARS-1:0] CMD_END  = "END_TEST";

   typedef enum logic [2:0] {BOOT, IDLE, WAIT_CLK, WAIT_EDGE, ACK, DONE} state_t;
   typedef struct packed {
      logic             ok;
      logic [NUM_W-1:0] val;
   } num_t;

   // Accepts an unsigned decimal or hex token; any stray character or an empty token fails.
   function automatic num_t parse_num(input logic [8*ARG_CHARS-1:0] s, input logic hex);
      num_t r;
      logic started, bad, dv;
      logic [7:0] c;
      logic [3:0] d;
      r = '0;
      started = 1'b0;
      bad = 1'b0;
      for (int k = ARG_CHARS - 1; k >= 0; k--) begin
         c = s[8*k +: 8];
         dv = 1'b0;
         d = 4'd0;
         if (c >= 8'h30 && c <= 8'h39) begin
            dv = 1'b1; d = 4'(c - 8'h30);
         end else if (hex && c >= 8'h61 && c <= 8'h66) begin
            dv = 1'b1; d = 4'(c - 8'h57);
         end else if (hex && c >= 8'h41 && c <= 8'h46) begin
            dv = 1'b1; d = 4'(c - 8'h37);
         end
         if (dv) begin
            started = 1'b1;
            r.val = hex ? {r.val[NUM_W-5:0], d} : NUM_W'(r.val * 10 + NUM_W'(d));
         end else if (c != 8'h00 || started) begin
            bad = 1'b1;
         end
      end
      r.ok = started && !bad;
      return r;
   endfunction

   state_t              state_reg, state_next;
   logic [NUM_W-1:0]    wcnt_reg, wcnt_next;
   logic [TW-1:0]       tcnt_reg, tcnt_next;
   logic [WI_W-1:0]     widx_reg, widx_next;
   logic                wpol_reg, wpol_next;
   logic [N_WAIT-1:0]   wprev_reg;
   logic [DATA_W-1:0]   set_out_reg [N_SET];
   logic [DATA_W-1:0]   set_out_next [N_SET];
   logic                busy_reg, busy_next;
   logic [15:0]         err_cnt_reg, err_next;
   logic                timeout_reg, timeout_next;
   logic                test_done_reg, test_done_next;

   num_t                p1d, p2h;
   logic                is_set, is_wclk, is_wtr, is_wtf, is_chk, is_end;
   logic [N_WAIT-1:0]   rise_v, fall_v, edge_sel;
   logic                cmd_err, proto_err;
   logic [16:0]         err_sum;
   logic                unused_args;

   assign p1d     = parse_num(args[1], 1'b0);
   assign p2h     = parse_num(args[2], 1'b1);
   assign is_set  = (args[0] == CMD_SET);
   assign is_wclk = (args[0] == CMD_WCLK);
   assign is_wtr  = (args[0] == CMD_WTR);
   assign is_wtf  = (args[0] == CMD_WTF);
   assign is_chk  = (args[0] == CMD_CHK);
   assign is_end  = (args[0] == CMD_END);
   assign rise_v  = wait_in & ~wprev_reg;
   assign fall_v  = ~wait_in & wprev_reg;
   assign unused_args = ^{args[3], args[4]};

   always_comb begin
      state_next     = state_reg;
      wcnt_next      = wcnt_reg;
      tcnt_next      = tcnt_reg;
      widx_next      = widx_reg;
      wpol_next      = wpol_reg;
      set_out_next   = set_out_reg;
      busy_next      = busy_reg;
      timeout_next   = timeout_reg;
      test_done_next = test_done_reg;
      cmd_err        = 1'b0;
      proto_err      = 1'b0;
      edge_sel       = is_wtr ? rise_v : fall_v;
      case (state_reg)
         BOOT: begin
            proto_err  = args_valid;
            state_next = ACK;
         end
         IDLE: begin
            if (args_valid) begin
               busy_next  = 1'b1;
               state_next = ACK;
               if (is_set) begin
                  if (p1d.ok && p2h.ok && p1d.val < NUM_W'(N_SET))
                     set_out_next[p1d.val[SI_W-1:0]] = DATA_W'(p2h.val);
                  else
                     cmd_err = 1'b1;
               end else if (is_wclk) begin
                  if (!p1d.ok) begin
                     cmd_err = 1'b1;
                  end else if (p1d.val > NUM_W'(1)) begin
                     wcnt_next  = p1d.val - 1'b1;
                     state_next = WAIT_CLK;
                  end
               end else if (is_wtr || is_wtf) begin
                  if (p1d.ok && p1d.val < NUM_W'(N_WAIT)) begin
                     widx_next = p1d.val[WI_W-1:0];
                     wpol_next = is_wtr;
                     // An edge already present on the decode cycle completes the wait.
                     if (!edge_sel[p1d.val[WI_W-1:0]]) begin
                        tcnt_next  = TW'(1);
                        state_next = WAIT_EDGE;
                     end
                  end else begin
                     cmd_err = 1'b1;
                  end
               end else if (is_chk) begin
                  if (p1d.ok && p2h.ok && p1d.val < NUM_W'(N_CHK))
                     cmd_err = (chk_in[p1d.val[CI_W-1:0]] != DATA_W'(p2h.val));
                  else
                     cmd_err = 1'b1;
               end else if (is_end) begin
                  test_done_next = 1'b1;
               end else begin
                  cmd_err = 1'b1;
               end
            end
         end
         WAIT_CLK: begin
            proto_err = args_valid;
            if (wcnt_reg == NUM_W'(1))
               state_next = ACK;
            else
               wcnt_next = wcnt_reg - 1'b1;
         end
         WAIT_EDGE: begin
            proto_err = args_valid;
            if (wpol_reg ? rise_v[widx_reg] : fall_v[widx_reg]) begin
               state_next = ACK;
            end else if (tcnt_reg == TW'(TIMEOUT)) begin
               timeout_next = 1'b1;
               cmd_err      = 1'b1;
               state_next   = ACK;
            end else begin
               tcnt_next = tcnt_reg + 1'b1;
            end
         end
         ACK: begin
            proto_err  = args_valid;
            busy_next  = 1'b0;
            state_next = test_done_reg ? DONE : IDLE;
         end
         DONE: begin
            proto_err = args_valid;
         end
         default: state_next = BOOT;
      endcase
      err_sum  = {1'b0, err_cnt_reg} + {16'd0, cmd_err} + {16'd0, proto_err};
      err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= BOOT;
         wcnt_reg      <= '0;
         tcnt_reg      <= '0;
         widx_reg      <= '0;
         wpol_reg      <= 1'b0;
         wprev_reg     <= '0;
         busy_reg      <= 1'b0;
         err_cnt_reg   <= '0;
         timeout_reg   <= 1'b0;
         test_done_reg <= 1'b0;
         for (int k = 0; k < N_SET; k++) set_out_reg[k] <= '0;
      end else begin
         state_reg     <= state_next;
         wcnt_reg      <= wcnt_next;
         tcnt_reg      <= tcnt_next;
         widx_reg      <= widx_next;
         wpol_reg      <= wpol_next;
         wprev_reg     <= wait_in;
         busy_reg      <= busy_next;
         err_cnt_reg   <= err_next;
         timeout_reg   <= timeout_next;
         test_done_reg <= test_done_next;
         for (int k = 0; k < N_SET; k++) set_out_reg[k] <= set_out_next[k];
      end
   end

   generate
      for (genvar gi = 0; gi < N_SET; gi++) begin : g_set_out
         assign set_out[gi] = set_out_reg[gi];
      end
   endgenerate

   assign ack          = (state_reg == ACK);
   assign busy         = busy_reg;
   assign err_cnt      = err_cnt_reg;
   assign timeout_flag = timeout_reg;
   assign test_done    = test_done_reg;
endmodule

// File: tb/tb_tb_cmd_executor.sv
// Self-checking bench for tb_cmd_executor: table of script lines with a scoreboard
// of expected ack latency / error state, plus reset-abort and END_TEST sequences.
module tb_tb_cmd_executor;
   localparam int DW = 32;
   localparam int AC = 16;
   localparam int TO = 100;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [8*AC-1:0]  args [5];
   logic             args_valid;
   logic             ack;
   logic [DW-1:0]    set_out [4];
   logic [3:0]       wait_in;
   logic [DW-1:0]    chk_in [4];
   logic             busy;
   logic [15:0]      err_cnt;
   logic             timeout_flag;
   logic             test_done;

   always #5 clk = ~clk;

   tb_cmd_executor #(
      .N_SET(4), .N_WAIT(4), .N_CHK(4), .DATA_W(DW), .TIMEOUT(TO), .ARG_CHARS(AC)
   ) dut (
      .clk(clk), .rst(rst), .args(args), .args_valid(args_valid), .ack(ack),
      .set_out(set_out), .wait_in(wait_in), .chk_in(chk_in), .busy(busy),
      .err_cnt(err_cnt), .timeout_flag(timeout_flag), .test_done(test_done)
   );

   typedef struct {
      logic [8*AC-1:0] a0, a1, a2;
      int              edge_at;   // cycle at which wait_in[edge_idx] is driven to edge_lvl, -1 none
      int              edge_idx;
      bit              edge_lvl;
      logic [DW-1:0]   chk1;
      int              spur_at;   // cycle of a stray args_valid, -1 none
      int              lat;
      int              err_inc;
      bit              to_set;
      int              set_idx;
      logic [DW-1:0]   set_val;
   } vec_t;

   typedef struct {
      int            lat;
      int            err;
      bit            to;
      int            set_idx;
      logic [DW-1:0] set_val;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_err = 0;
   bit   exp_to = 1'b0;

   function automatic vec_t mk(input logic [8*AC-1:0] a0, a1, a2, input int edge_at, edge_idx,
                               input bit edge_lvl, input logic [DW-1:0] chk1, input int spur_at,
                               lat, err_inc, input bit to_set, input int set_idx,
                               input logic [DW-1:0] set_val);
      vec_t v;
      v.a0 = a0; v.a1 = a1; v.a2 = a2;
      v.edge_at = edge_at; v.edge_idx = edge_idx; v.edge_lvl = edge_lvl;
      v.chk1 = chk1; v.spur_at = spur_at; v.lat = lat; v.err_inc = err_inc;
      v.to_set = to_set; v.set_idx = set_idx; v.set_val = set_val;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Waits for the first ack after reset release; ack seen after the 1st posedge is
   // latched by the sequencer on the 2nd.
   task automatic boot_latency(output int lat);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (ack) begin lat = k; break; end
      end
   endtask

   // Issues one line in the cycle after the previous ack and returns the ack cycle.
   task automatic run_cmd(input vec_t v, output int lat);
      @(posedge clk); #1;
      args[0] = v.a0; args[1] = v.a1; args[2] = v.a2; args[3] = '0; args[4] = '0;
      chk_in[1] = v.chk1;
      args_valid = 1'b1;
      if (v.edge_at == 0) wait_in[v.edge_idx] = v.edge_lvl;
      lat = -1;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk); #1;
         args_valid = (k == v.spur_at);
         if (ack) begin lat = k; break; end
         if (k == v.edge_at) wait_in[v.edge_idx] = v.edge_lvl;
      end
      args_valid = 1'b0;
   endtask

   initial begin
      int   lat;
      int   acks;
      exp_t e;
      vec_t v;

      args_valid = 1'b0;
      wait_in = '0;
      for (int i = 0; i < 5; i++) args[i] = '0;
      for (int i = 0; i < 4; i++) chk_in[i] = '0;

      vecs.push_back(mk("SET", "0", "DEADBEEF", -1, 0, 0, 0, -1, 1, 0, 0, 0, 32'hDEADBEEF));
      vecs.push_back(mk("WAIT_CLK", "5", "", -1, 0, 0, 0, -1, 5, 0, 0, -1, 0));
      vecs.push_back(mk("WAIT_CLK", "0", "", -1, 0, 0, 0, -1, 1, 0, 0, -1, 0));
      vecs.push_back(mk("WAIT_CLK", "2", "", -1, 0, 0, 0, -1, 2, 0, 0, -1, 0));
      vecs.push_back(mk("WAIT_CLK", "4", "", -1, 0, 0, 0, 2, 4, 1, 0, -1, 0));
      vecs.push_back(mk("WTR", "2", "", 37, 2, 1, 0, -1, 38, 0, 0, -1, 0));
      vecs.push_back(mk("WTF", "2", "", 5, 2, 0, 0, -1, 6, 0, 0, -1, 0));
      vecs.push_back(mk("WTR", "1", "", 0, 1, 1, 0, -1, 1, 0, 0, -1, 0));
      vecs.push_back(mk("CHK", "1", "00000012", -1, 0, 0, 32'h12, -1, 1, 0, 0, -1, 0));
      vecs.push_back(mk("CHK", "1", "00000012", -1, 0, 0, 32'h13, -1, 1, 1, 0, -1, 0));
      vecs.push_back(mk("SET", "9", "1", -1, 0, 0, 0, -1, 1, 1, 0, -1, 0));
      vecs.push_back(mk("FOO", "", "", -1, 0, 0, 0, -1, 1, 1, 0, -1, 0));
      vecs.push_back(mk("SET", "3", "XYZ", -1, 0, 0, 0, -1, 1, 1, 0, 3, 0));
      vecs.push_back(mk("WTR", "3", "", -1, 0, 0, 0, -1, TO + 1, 1, 1, -1, 0));
      vecs.push_back(mk("SET", "2", "0000abcd", -1, 0, 0, 0, -1, 1, 0, 0, 2, 32'h0000ABCD));
      vecs.push_back(mk("WTR", "7", "", -1, 0, 0, 0, -1, 1, 1, 0, -1, 0));

      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", ack, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_cnt, 0);
      check("rst_timeout", timeout_flag, 0);
      check("rst_done", test_done, 0);
      check("rst_set0", set_out[0], 0);
      rst = 1'b0;
      boot_latency(lat);
      check("boot_lat", lat, 1);

      foreach (vecs[i]) begin
         v = vecs[i];
         exp_err += v.err_inc;
         exp_to |= v.to_set;
         e.lat = v.lat; e.err = exp_err; e.to = exp_to;
         e.set_idx = v.set_idx; e.set_val = v.set_val;
         sb.push_back(e);
         run_cmd(v, lat);
         e = sb.pop_front();
         $display("cmd %0d %s: ack_lat=%0d exp=%0d err_cnt=%0d exp=%0d", i, v.a0, lat, e.lat,
                  err_cnt, e.err);
         check("ack_lat", lat, e.lat);
         check("err_cnt", err_cnt, e.err);
         check("timeout_flag", timeout_flag, e.to);
         if (e.set_idx >= 0) check("set_out", set_out[e.set_idx], e.set_val);
      end

      // Reset asserted at cycle 10 of WAIT_CLK 50 aborts the command.
      @(posedge clk); #1;
      args[0] = "WAIT_CLK"; args[1] = "50"; args[2] = '0;
      args_valid = 1'b1;
      acks = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         args_valid = 1'b0;
         if (ack) acks++;
      end
      check("wclk50_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_err", err_cnt, 0);
      check("abort_timeout", timeout_flag, 0);
      check("abort_set0", set_out[0], 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      check("no_ack_wait_reset", acks, 0);
      rst = 1'b0;
      boot_latency(lat);
      $display("reset abort: reboot ack_lat=%0d", lat);
      check("reboot_lat", lat, 1);

      v = mk("END_TEST", "", "", -1, 0, 0, 0, -1, 1, 0, 0, -1, 0);
      run_cmd(v, lat);
      $display("cmd END_TEST: ack_lat=%0d test_done=%0b", lat, test_done);
      check("end_lat", lat, 1);
      check("test_done", test_done, 1);

      @(posedge clk); #1;
      args[0] = "SET"; args[1] = "0"; args[2] = "1";
      args_valid = 1'b1;
      acks = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         args_valid = 1'b0;
         if (ack) acks++;
      end
      $display("after END_TEST: acks=%0d", acks);
      check("done_no_ack", acks, 0);
      check("done_set_ignored", set_out[0], 0);
      check("done_sticky", test_done, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
